iter_shifter: RTL and testbench

//   Multi-cycle sequential shifter: the iterative counterpart of the single-cycle
//   <<, >>, <<< and >>> operator datapath. It shifts one bit position per clock.

---
 rtl/iter_shifter.sv | 83 ++++++++
 tb/tb_iter_shifter.sv | 111 +++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter (LSL/LSR/ASR/ROR), one bit per clock, start/busy/done handshake.
//   Params : WIDTH data width, SHAMT_W shift-amount width
//   Ports  : clk, rst_n (async active-low), start, op[1:0], din, amt -> busy, done, dout
//   Config : ITER_SHIFTER_ROR_EN enables rotate-right on op=11; otherwise op=11 acts as LSR
module iter_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, dout_q, dout_d, step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic done_q, done_d;
  logic accept;
  assign accept = (state_q == IDLE) && start;
  always_comb begin
`ifdef ITER_SHIFTER_ROR_EN
    step = (op_q == 2'b00) ? {work_q[WIDTH-2:0], 1'b0} :
           (op_q == 2'b10) ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} :
           (op_q == 2'b11) ? {work_q[0], work_q[WIDTH-1:1]} :
                             {1'b0, work_q[WIDTH-1:1]};
`else
    step = (op_q == 2'b00) ? {work_q[WIDTH-2:0], 1'b0} :
           (op_q == 2'b10) ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} :
                             {1'b0, work_q[WIDTH-1:1]};
`endif
  end
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    if (accept) begin
      work_d  = din;
      cnt_d   = amt;
      op_d    = op;
      state_d = (amt == '0) ? IDLE : SHIFT;
      // zero-length shift completes straight from IDLE
      dout_d  = (amt == '0) ? din : dout_q;
      done_d  = (amt == '0);
    end else if (state_q == SHIFT) begin
      work_d = step;
      cnt_d  = cnt_q - SHAMT_W'(1);
      // count==1 means this edge performs the final step
      state_d = (cnt_q == SHAMT_W'(1)) ? IDLE : SHIFT;
      dout_d  = (cnt_q == SHAMT_W'(1)) ? step : dout_q;
      done_d  = (cnt_q == SHAMT_W'(1));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end
  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign dout = dout_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized self-checking bench for iter_shifter against an arithmetic reference.
module tb_iter_shifter;
  localparam int W  = 8;
  localparam int SW = 3;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  din = '0;
  logic [SW-1:0] amt = '0;
  logic          busy, done;
  logic [W-1:0]  dout;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_dout = '0;
  iter_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .din(din), .amt(amt),
    .busy(busy), .done(done), .dout(dout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] d, input int n);
    logic [2*W-1:0] dd;
    dd = {d, d};
    if (o == 2'd0) return (n >= W) ? '0 : W'(d << n);
    if (o == 2'd2) return W'($signed(d) >>> ((n >= W) ? W - 1 : n));
`ifdef ITER_SHIFTER_ROR_EN
    if (o == 2'd3) return W'(dd >> (n % W));
`endif
    return (n >= W) ? '0 : W'(d >> n);
  endfunction
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_dout", 32'(dout), 32'(exp_dout));
    end
  endtask
  // Called at posedge+1; returns at posedge+1 of the done cycle, so calls chain back-to-back.
  task automatic run(input logic [1:0] o, input logic [W-1:0] d, input int n, input bit junk);
    logic [W-1:0] nxt;
    nxt = ref_shift(o, d, n);
    start = 1'b1; op = o; din = d; amt = SW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      check("busy", 32'(busy), 32'(c <= n));
      check("done", 32'(done), 32'(c == n + 1));
      check("dout", 32'(dout), 32'((c == n + 1) ? nxt : exp_dout));
      if (junk && c <= n) begin
        start = 1'b1; din = '1; op = 2'($urandom); amt = SW'($urandom);
      end else start = 1'b0;
    end
    exp_dout = nxt;
  endtask
  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    run(2'd0, 8'hA5, 3, 0); check("t1_lsl", 32'(dout), 32'h28);
    run(2'd1, 8'hA5, 3, 0); check("t2_lsr", 32'(dout), 32'h14);
    run(2'd2, 8'hA5, 3, 0); check("t2_asr", 32'(dout), 32'hF4);
    run(2'd2, 8'h80, 7, 0); check("t2_asr7", 32'(dout), 32'hFF);
    idle(2);
    run(2'd3, 8'hA5, 3, 0);
`ifdef ITER_SHIFTER_ROR_EN
    check("t3_ror", 32'(dout), 32'hB4);
`else
    check("t3_ror_as_lsr", 32'(dout), 32'h14);
`endif
    for (int o = 0; o < 4; o++) begin
      run(2'(o), 8'h3C, 0, 0);
      check("t4_amt0", 32'(dout), 32'h3C);
    end
    run(2'd0, 8'hA5, 3, 1); check("t5_ignore", 32'(dout), 32'h28);
    run(2'd1, 8'hA5, 3, 0); check("t5_b2b", 32'(dout), 32'h14);
    idle(1);
    start = 1'b1; op = 2'd0; din = 8'h5A; amt = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_dout", 32'(dout), 32'd0);
    exp_dout = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    run(2'd1, 8'hA5, 3, 0); check("t6_after", 32'(dout), 32'h14);
    for (int i = 0; i < 300; i++) begin
      run(2'($urandom), W'($urandom), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
